// File: rtl/debug_dump_sequencer_pkg.sv
// Shared definitions for the debug dump path: sequencer state encodings and
// the default dump geometry, also used by the debug control FSM.
package debug_dump_sequencer_pkg;

  localparam int DEF_NB_DATA       = 32;
  localparam int DEF_N_REGISTERS   = 32;
  localparam int DEF_N_ADDR_D_MEM  = 32;
  localparam bit DEF_SEND_CHECKSUM = 1'b1;

  // Words sent per dump: PC, every register, every memory word, optional checksum.
  localparam int DUMP_WORDS = 1 + DEF_N_REGISTERS + DEF_N_ADDR_D_MEM + int'(DEF_SEND_CHECKSUM);

  // One-hot sequencer states.
  typedef enum logic [7:0] {
    ST_IDLE      = 8'b0000_0001,
    ST_SEND_PC   = 8'b0000_0010,
    ST_REG_RD    = 8'b0000_0100,
    ST_REG_TX    = 8'b0000_1000,
    ST_MEM_RD    = 8'b0001_0000,
    ST_MEM_TX    = 8'b0010_0000,
    ST_SEND_CSUM = 8'b0100_0000,
    ST_DONE      = 8'b1000_0000
  } state_e;

endpackage

// File: rtl/debug_dump_sequencer.sv
// Debug state dump sequencer: after a start pulse it streams PC, every CPU
// register, every data-memory word and (optionally) a wrap-around checksum
// of those words to the transmitter, one word per handshake.
//
// Transmit handshake: a word is offered with o_tx_valid=1 and o_tx_data held
// stable until a rising edge sees o_tx_valid & i_tx_ready, which is the
// transfer; i_tx_ready has no effect while o_tx_valid=0.
//
// Register file and data memory have a one-cycle synchronous read. The RD
// state presents the address; on the first TX cycle the read data is passed
// straight through to o_tx_data and also latched, so the word stays stable
// through any stall even if the memory output changes afterwards.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int NB_DATA           = DEF_NB_DATA,
  parameter int NB_ADDRESS        = 32,
  parameter int N_REGISTERS       = DEF_N_REGISTERS,
  parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS),
  parameter int N_ADDR_D_MEM      = DEF_N_ADDR_D_MEM,
  parameter int NB_ADDR_D_MEM     = $clog2(N_ADDR_D_MEM),
  parameter bit SEND_CHECKSUM     = DEF_SEND_CHECKSUM
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [NB_DATA-1:0]           i_pc,
  output logic [NB_ADDR_REGISTERS-1:0] o_reg_addr,
  input  logic [NB_DATA-1:0]           i_reg_data,
  output logic [NB_ADDRESS-1:0]        o_dmem_addr,
  output logic                         o_dmem_rd_en,
  input  logic [NB_DATA-1:0]           i_dmem_data,
  output logic [NB_DATA-1:0]           o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output state_e                       o_dbg_state
);

  localparam logic [NB_ADDR_REGISTERS-1:0] REG_LAST = NB_ADDR_REGISTERS'(N_REGISTERS - 1);
  localparam logic [NB_ADDR_D_MEM-1:0]     MEM_LAST = NB_ADDR_D_MEM'(N_ADDR_D_MEM - 1);

  state_e                       state_q, state_d;
  logic [NB_ADDR_REGISTERS-1:0] reg_it_q, reg_it_d;
  logic [NB_ADDR_D_MEM-1:0]     mem_it_q, mem_it_d;
  logic [NB_DATA-1:0]           csum_q, csum_d;
  logic [NB_DATA-1:0]           hold_q, hold_d;
  logic                         first_q;
  logic [NB_DATA-1:0]           tx_data;
  logic                         tx_valid;

  // Next-state, iterator, checksum and transmit-word selection.
  always_comb begin
    state_d  = state_q;
    reg_it_d = reg_it_q;
    mem_it_d = mem_it_q;
    csum_d   = csum_q;
    hold_d   = hold_q;
    tx_valid = 1'b0;
    tx_data  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          hold_d  = i_pc;
          csum_d  = '0;
          state_d = ST_SEND_PC;
        end
      end
      ST_SEND_PC: begin
        tx_valid = 1'b1;
        if (i_tx_ready) begin
          csum_d   = csum_q + tx_data;
          reg_it_d = '0;
          state_d  = ST_REG_RD;
        end
      end
      ST_REG_RD: begin
        state_d = ST_REG_TX;
      end
      ST_REG_TX: begin
        tx_valid = 1'b1;
        if (first_q) tx_data = i_reg_data;
        hold_d = tx_data;
        if (i_tx_ready) begin
          csum_d = csum_q + tx_data;
          if (reg_it_q == REG_LAST) begin
            mem_it_d = '0;
            state_d  = ST_MEM_RD;
          end else begin
            reg_it_d = reg_it_q + NB_ADDR_REGISTERS'(1);
            state_d  = ST_REG_RD;
          end
        end
      end
      ST_MEM_RD: begin
        state_d = ST_MEM_TX;
      end
      ST_MEM_TX: begin
        tx_valid = 1'b1;
        if (first_q) tx_data = i_dmem_data;
        hold_d = tx_data;
        if (i_tx_ready) begin
          csum_d = csum_q + tx_data;
          if (mem_it_q == MEM_LAST) begin
            state_d = SEND_CHECKSUM ? ST_SEND_CSUM : ST_DONE;
          end else begin
            mem_it_d = mem_it_q + NB_ADDR_D_MEM'(1);
            state_d  = ST_MEM_RD;
          end
        end
      end
      ST_SEND_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (i_tx_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, iterators, checksum and held word; reset aborts any dump in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      reg_it_q <= '0;
      mem_it_q <= '0;
      csum_q   <= '0;
      hold_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_it_q <= reg_it_d;
      mem_it_q <= mem_it_d;
      csum_q   <= csum_d;
      hold_q   <= hold_d;
      first_q  <= (state_q == ST_REG_RD) || (state_q == ST_MEM_RD);
    end
  end

  assign o_tx_valid   = tx_valid;
  assign o_tx_data    = tx_data;
  assign o_reg_addr   = reg_it_q;
  assign o_dmem_addr  = NB_ADDRESS'(mem_it_q);
  assign o_dmem_rd_en = (state_q == ST_MEM_RD);
  assign o_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done       = (state_q == ST_DONE);
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: default-geometry instance plus a small
// instance (8 regs, 4 mem words, no checksum), with register-file and
// data-memory models and a transfer monitor feeding per-test comparisons.
module tb_debug_dump_sequencer;
  import debug_dump_sequencer_pkg::*;

  localparam int NR   = 32;
  localparam int NM   = 32;
  localparam int NR_S = 8;
  localparam int NM_S = 4;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- default instance ----------------
  logic        start, tx_ready, dmem_rd_en, tx_valid, busy, done;
  logic [31:0] pc, reg_data, dmem_addr, dmem_data, tx_data;
  logic [4:0]  reg_addr;
  state_e      dbg_state;

  debug_dump_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_pc(pc),
    .o_reg_addr(reg_addr), .i_reg_data(reg_data),
    .o_dmem_addr(dmem_addr), .o_dmem_rd_en(dmem_rd_en), .i_dmem_data(dmem_data),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
  );

  // ---------------- small instance ----------------
  logic        start_s, tx_ready_s, rd_en_s, tx_valid_s, busy_s, done_s;
  logic [31:0] pc_s, reg_data_s, dmem_addr_s, dmem_data_s, tx_data_s;
  logic [2:0]  reg_addr_s;
  state_e      dbg_state_s;

  debug_dump_sequencer #(
    .N_REGISTERS(NR_S), .N_ADDR_D_MEM(NM_S), .SEND_CHECKSUM(1'b0)
  ) dut_s (
    .i_clk(clk), .i_reset(reset), .i_start(start_s), .i_pc(pc_s),
    .o_reg_addr(reg_addr_s), .i_reg_data(reg_data_s),
    .o_dmem_addr(dmem_addr_s), .o_dmem_rd_en(rd_en_s), .i_dmem_data(dmem_data_s),
    .o_tx_data(tx_data_s), .o_tx_valid(tx_valid_s), .i_tx_ready(tx_ready_s),
    .o_busy(busy_s), .o_done(done_s), .o_dbg_state(dbg_state_s)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] reg_val(input int k);
    return 32'(k) * 32'h11;
  endfunction

  function automatic logic [31:0] mem_val(input int k);
    return 32'hA000_0000 + 32'(k);
  endfunction

  // Synchronous-read register files; data memory output only moves after a read.
  always @(posedge clk) begin
    reg_data   <= reg_val(int'(reg_addr));
    reg_data_s <= reg_val(int'(reg_addr_s));
    if (dmem_rd_en) dmem_data   <= mem_val(int'(dmem_addr));
    if (rd_en_s)    dmem_data_s <= mem_val(int'(dmem_addr_s));
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] got_s_q[$];
  logic [31:0] rd_addr_s_q[$];
  int          done_cnt, done_cnt_s, stall_err, rd_cnt_s;
  bit          prev_stall;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) done_cnt++;
      if (tx_valid_s && tx_ready_s) got_s_q.push_back(tx_data_s);
      if (rd_en_s) begin
        rd_cnt_s++;
        rd_addr_s_q.push_back(dmem_addr_s);
      end
      if (done_s) done_cnt_s++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic build_exp(input logic [31:0] pc_v, input int nr, input int nm, input bit csum);
    logic [31:0] sum;
    exp_q.delete();
    exp_q.push_back(pc_v);
    sum = pc_v;
    for (int k = 0; k < nr; k++) begin exp_q.push_back(reg_val(k)); sum += reg_val(k); end
    for (int k = 0; k < nm; k++) begin exp_q.push_back(mem_val(k)); sum += mem_val(k); end
    if (csum) exp_q.push_back(sum);
  endtask

  task automatic start_dump(input logic [31:0] pc_v);
    got_q.delete();
    done_cnt  = 0;
    stall_err = 0;
    pc    = pc_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pc    = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input int max_cyc, input bit rand_ready, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < max_cyc) begin
      if (rand_ready) tx_ready = ($urandom_range(0, 99) < 30);
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    tx_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dmem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", dmem_rd_en); end
    checks++; if (tx_data !== 32'h0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
    checks++; if (reg_addr !== 5'd0 || dmem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_addr got=%h/%h exp=0/0", reg_addr, dmem_addr); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%h exp=%h", dbg_state, ST_IDLE); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset busy=%b valid=%b exp=0/0", busy, tx_valid); end
  endtask

  task automatic test_basic_dump();
    int cyc; bit seen;
    build_exp(32'h0000_0040, NR, NM, 1'b1);
    start_dump(32'h0000_0040);
    checks++; if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 32'h40) begin
      failures++; $display("FAIL basic_first busy=%b valid=%b data=%h exp=1/1/00000040", busy, tx_valid, tx_data); end
    wait_done(400, 1'b0, cyc, seen);
    checks++; if (!seen) begin failures++; $display("FAIL basic_timeout no done within 400 cycles"); end
    checks++; if (cyc != 2 * (NR + NM) + 1 + 1) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, 2 * (NR + NM) + 2); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
    repeat (3) @(posedge clk); #1;
    checks++; if (got_q.size() != DUMP_WORDS) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), DUMP_WORDS); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== 32'h0000_2320) begin
      failures++; $display("FAIL basic_checksum got=%h exp=00002320", got_q.size() ? got_q[got_q.size()-1] : 32'hx); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int cyc; bit seen;
    build_exp(32'h0000_0040, NR, NM, 1'b1);
    start_dump(32'h0000_0040);
    wait_done(2000, 1'b1, cyc, seen);
    checks++; if (!seen) begin failures++; $display("FAIL bp_timeout no done within 2000 cycles"); end
    repeat (3) @(posedge clk); #1;
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stable got=%0d unstable stalls exp=0", stall_err); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    int cyc; bit seen;
    build_exp(32'h0000_0040, NR, NM, 1'b1);
    start_dump(32'h0000_0040);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      start = (cyc == 5 || cyc == 40);
      pc    = 32'h5555_0000 + 32'(cyc);
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL ign_timeout no done within 400 cycles"); end
    checks++; if (cyc != 2 * (NR + NM) + 2) begin failures++; $display("FAIL ign_latency got=%0d exp=%0d", cyc, 2 * (NR + NM) + 2); end
    // Start during the DONE cycle must be dropped.
    start = 1'b1; pc = 32'h0000_7777;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL ign_done_start busy=%b valid=%b state=%h exp=0/0/%h", busy, tx_valid, dbg_state, ST_IDLE); end
    checks++; if (got_q.size() != DUMP_WORDS) begin failures++; $display("FAIL ign_count got=%0d exp=%0d", got_q.size(), DUMP_WORDS); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ign_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ign_done_pulses got=%0d exp=1", done_cnt); end
    // Start in the cycle right after DONE is accepted.
    build_exp(32'h0000_0100, NR, NM, 1'b1);
    start_dump(32'h0000_0100);
    checks++; if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 32'h100) begin
      failures++; $display("FAIL ign_restart busy=%b valid=%b data=%h exp=1/1/00000100", busy, tx_valid, tx_data); end
    wait_done(400, 1'b0, cyc, seen);
    repeat (2) @(posedge clk); #1;
    checks++; if (got_q.size() != DUMP_WORDS || got_q[got_q.size()-1] !== 32'h0000_23E0) begin
      failures++; $display("FAIL ign_restart_dump count=%0d exp=%0d last exp=000023e0", got_q.size(), DUMP_WORDS); end
  endtask

  task automatic test_reset_mid_dump();
    int cyc; bit seen; bit found;
    start_dump(32'h0000_0040);
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (dbg_state == ST_MEM_TX && tx_data == mem_val(10)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rst_find_m10 not reached within 400 cycles"); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rst_abort valid=%b busy=%b done=%b exp=0/0/0", tx_valid, busy, done); end
    repeat (5) @(posedge clk); #1;
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt); end
    build_exp(32'h0000_0100, NR, NM, 1'b1);
    start_dump(32'h0000_0100);
    wait_done(400, 1'b0, cyc, seen);
    checks++; if (!seen) begin failures++; $display("FAIL rst_restart_timeout no done within 400 cycles"); end
    repeat (2) @(posedge clk); #1;
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== 32'h0000_23E0) begin
      failures++; $display("FAIL rst_checksum got=%h exp=000023e0", got_q.size() ? got_q[got_q.size()-1] : 32'hx); end
  endtask

  task automatic test_small_config();
    int cyc;
    build_exp(32'h0000_0040, NR_S, NM_S, 1'b0);
    got_s_q.delete();
    rd_addr_s_q.delete();
    rd_cnt_s   = 0;
    done_cnt_s = 0;
    pc_s    = 32'h0000_0040;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    cyc = 0;
    while (!done_s && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc != 2 * (NR_S + NM_S) + 1) begin failures++; $display("FAIL small_latency got=%0d exp=%0d", cyc, 2 * (NR_S + NM_S) + 1); end
    repeat (3) @(posedge clk); #1;
    checks++; if (got_s_q.size() != 13) begin failures++; $display("FAIL small_count got=%0d exp=13", got_s_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_s_q.size(); i++) begin
      checks++; if (got_s_q[i] !== exp_q[i]) begin failures++; $display("FAIL small_word[%0d] got=%h exp=%h", i, got_s_q[i], exp_q[i]); end
    end
    checks++; if (got_s_q.size() == 0 || got_s_q[got_s_q.size()-1] !== 32'hA000_0003) begin
      failures++; $display("FAIL small_last got=%h exp=a0000003", got_s_q.size() ? got_s_q[got_s_q.size()-1] : 32'hx); end
    checks++; if (rd_cnt_s != 4) begin failures++; $display("FAIL small_rd_en_cycles got=%0d exp=4", rd_cnt_s); end
    for (int i = 0; i < rd_addr_s_q.size(); i++) begin
      checks++; if (rd_addr_s_q[i] !== 32'(i)) begin failures++; $display("FAIL small_rd_addr[%0d] got=%h exp=%h", i, rd_addr_s_q[i], 32'(i)); end
    end
    checks++; if (done_cnt_s != 1 || busy_s !== 1'b0) begin
      failures++; $display("FAIL small_done pulses=%0d busy=%b exp=1/0", done_cnt_s, busy_s); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    pc         = 32'h0;
    tx_ready   = 1'b1;
    start_s    = 1'b0;
    pc_s       = 32'h0;
    tx_ready_s = 1'b1;
    test_reset();
    test_basic_dump();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_dump();
    test_small_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
